datapath_trace_buffer: RTL and testbench

// - Hardware consumer for the core's per-cycle observation outputs (pc, result); replaces the printf-style monitor.
// - Arms on a trigger PC and captures {pc,result} pairs into an on-chip FIFO.
// - Halts when full; the host drains entries over a valid/ready read port.
// - Sits beside the datapath instance, fed by the same clk.

---
 rtl/datapath_pkg.sv | 19 +
 rtl/trace_fifo.sv | 76 +++++++
 rtl/datapath_trace_buffer.sv | 112 +++++++++++
 tb/tb_datapath_trace_buffer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath trace buffer: width defaults, trace state encoding,
// and the width of one {pc,result} trace entry.
package datapath_pkg;

  localparam int PC_W_DEF   = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HALTED  = 2'd3
  } trace_state_e;

  function automatic int entry_w(input int pc_w, input int data_w);
    return pc_w + data_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is held in a register so that
// rd_data keeps its last value after the FIFO drains.
module trace_fifo
  import datapath_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [W-1:0]     r_head;

  logic [CNT_W-1:0] w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_rd_next_idx;

  assign w_level       = r_wr_cnt - r_rd_cnt;
  assign w_empty       = (w_level == '0);
  assign w_full        = (w_level == CNT_W'(DEPTH));
  // A full FIFO never accepts, even when a pop frees a slot in the same cycle.
  assign w_push_ok     = push && !w_full && !flush;
  assign w_pop_ok      = pop && !w_empty && !flush;
  assign w_rd_next_idx = r_rd_cnt[AW-1:0] + AW'(1);

  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_mem[r_wr_cnt[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_head   <= '0;
    end else begin
      if (w_push_ok) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      if (w_pop_ok)  r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      // Look ahead to the next head: the stored successor, or the entry arriving now.
      if (w_pop_ok) begin
        if (w_level > CNT_W'(1)) begin
          r_head <= r_mem[w_rd_next_idx];
        end else if (w_push_ok) begin
          r_head <= push_data;
        end
      end else if (w_empty && w_push_ok) begin
        r_head <= push_data;
      end
    end
  end

  assign rd_data = r_head;
  assign empty   = w_empty;
  assign full    = w_full;
  assign level   = w_level;

endmodule

// File: rtl/datapath_trace_buffer.sv
// Trigger-armed trace capture of the datapath {pc,result} stream into a FIFO drained by the host.
// Optional build macro TRACE_PC_CHANGE_FILTER_EN collapses repeated pc values while capturing.
module datapath_trace_buffer
  import datapath_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PC_W-1:0]          pc,
  input  logic [DATA_W-1:0]        result,
  input  logic                     arm,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     clear,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [PC_W+DATA_W-1:0]   rd_data,
  output logic [CNT_W-1:0]         level,
  output logic [1:0]               state_o
);

  localparam int ENTRY_W = entry_w(PC_W, DATA_W);

  trace_state_e       r_state;
`ifdef TRACE_PC_CHANGE_FILTER_EN
  logic [PC_W-1:0]    r_last_pc;
`endif

  logic               w_match;
  logic               w_push_req;
  logic               w_push_ok;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [CNT_W-1:0]   w_level;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_rd_data;

  assign w_match = (pc == trig_pc);
  assign w_entry = {pc, result};
  assign w_pop   = rd_ready && !w_empty;

  always_comb begin
    w_push_req = 1'b0;
    if (!clear) begin
      case (r_state)
        ST_ARMED:   w_push_req = w_match;
`ifdef TRACE_PC_CHANGE_FILTER_EN
        ST_CAPTURE: w_push_req = (pc != r_last_pc);
`else
        ST_CAPTURE: w_push_req = 1'b1;
`endif
        default:    w_push_req = 1'b0;
      endcase
    end
  end

  assign w_push_ok = w_push_req && !w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (arm) r_state <= ST_ARMED;
        ST_ARMED:   if (w_match) r_state <= ST_CAPTURE;
        // Halt only on the push that actually fills the FIFO; push+pop keeps the level.
        ST_CAPTURE: if (w_push_ok && !w_pop && w_level == CNT_W'(DEPTH - 1)) r_state <= ST_HALTED;
        ST_HALTED:  r_state <= ST_HALTED;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef TRACE_PC_CHANGE_FILTER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_pc <= '0;
    end else if (w_push_ok) begin
      r_last_pc <= pc;
    end
  end
`endif

  trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (w_push_ok),
    .push_data (w_entry),
    .pop       (w_pop),
    .rd_data   (w_rd_data),
    .empty     (w_empty),
    .full      (w_full),
    .level     (w_level)
  );

  assign rd_valid = !w_empty;
  assign rd_data  = w_rd_data;
  assign level    = w_level;
  assign state_o  = r_state;

endmodule

// File: tb/tb_datapath_trace_buffer.sv
// Directed bench for datapath_trace_buffer: a vector table for arm/trigger/push-pop/clear,
// plus hand sequences for fill-to-halt, drain, reset mid-capture and pc-change filtering.
module tb_datapath_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc;
  logic [31:0] result;
  logic        arm;
  logic [7:0]  trig_pc;
  logic        clear;
  logic        rd_valid;
  logic        rd_ready;
  logic [39:0] rd_data;
  logic [4:0]  level;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  datapath_trace_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .result   (result),
    .arm      (arm),
    .trig_pc  (trig_pc),
    .clear    (clear),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic        clear;
    logic        rd_ready;
    logic [7:0]  pc;
    logic [31:0] res;
    logic [1:0]  st;
    logic [4:0]  lvl;
    logic        vld;
    logic        chk_data;
    logic [39:0] data;
  } vec_t;

  vec_t vecs[10];
  logic [39:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pc = '0; result = '0; arm = 1'b0; trig_pc = 8'h04; clear = 1'b0; rd_ready = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 32'hA000_0000, 2'd1, 5'd0, 1'b0, 1'b1, 40'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h04, 32'hA000_0004, 2'd2, 5'd1, 1'b1, 1'b1, 40'h04_A000_0004};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h08, 32'hA000_0008, 2'd2, 5'd2, 1'b1, 1'b1, 40'h04_A000_0004};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h0C, 32'hA000_000C, 2'd2, 5'd3, 1'b1, 1'b1, 40'h04_A000_0004};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h10, 32'hA000_0010, 2'd2, 5'd3, 1'b1, 1'b1, 40'h08_A000_0008};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h14, 32'hA000_0014, 2'd2, 5'd3, 1'b1, 1'b1, 40'h0C_A000_000C};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h18, 32'hA000_0018, 2'd2, 5'd3, 1'b1, 1'b1, 40'h10_A000_0010};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h1C, 32'hA000_001C, 2'd0, 5'd0, 1'b0, 1'b0, 40'h0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 8'h04, 32'hA000_0104, 2'd1, 5'd0, 1'b0, 1'b0, 40'h0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'hA000_0200, 2'd1, 5'd0, 1'b0, 1'b0, 40'h0};

    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_state", 64'(state_o), 64'd0);
    check("reset_level", 64'(level), 64'd0);
    check("reset_valid", 64'(rd_valid), 64'd0);
    check("reset_data", 64'(rd_data), 64'd0);
    $display("reset: state=%0d level=%0d", state_o, level);

    // Table: arm, trigger at pc=04, fill to 3, concurrent push/pop, clear, re-arm.
    for (int i = 0; i < 10; i++) begin
      arm = vecs[i].arm; clear = vecs[i].clear; rd_ready = vecs[i].rd_ready;
      pc = vecs[i].pc; result = vecs[i].res;
      tick();
      check($sformatf("vec%0d_state", i), 64'(state_o), 64'(vecs[i].st));
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].lvl));
      check($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].vld));
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), 64'(rd_data), 64'(vecs[i].data));
      $display("vec%0d: pc=%02h state=%0d level=%0d rd_data=%010h", i, vecs[i].pc, state_o, level, rd_data);
    end
    arm = 1'b0; clear = 1'b0; rd_ready = 1'b0;

    // Fill: 20 capture cycles from ARMED, only the first 16 are stored.
    for (int i = 0; i < 20; i++) begin
      pc = 8'(8'h04 + 4 * i);
      result = 32'hD000_0000 | 32'(i);
      if (i < 16) exp_q.push_back({pc, result});
      tick();
      if (i == 14) begin
        check("fill_pre_state", 64'(state_o), 64'd2);
        check("fill_pre_level", 64'(level), 64'd15);
      end
      if (i == 15) begin
        check("fill_halt_state", 64'(state_o), 64'd3);
        check("fill_halt_level", 64'(level), 64'd16);
      end
      $display("fill%0d: pc=%02h state=%0d level=%0d", i, pc, state_o, level);
    end
    check("fill_end_level", 64'(level), 64'd16);
    check("fill_end_state", 64'(state_o), 64'd3);
    check("fill_end_head", 64'(rd_data), 64'(exp_q[0]));

    // Drain all 16 in order while HALTED, then pop on empty.
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d_valid", k), 64'(rd_valid), 64'd1);
      check($sformatf("drain%0d_data", k), 64'(rd_data), 64'(exp_q[k]));
      $display("drain%0d: rd_data=%010h", k, rd_data);
      tick();
    end
    check("drain_empty_valid", 64'(rd_valid), 64'd0);
    check("drain_state", 64'(state_o), 64'd3);
    tick();
    check("empty_pop_hold", 64'(rd_data), 64'(exp_q[15]));
    check("empty_pop_level", 64'(level), 64'd0);
    check("halted_stays", 64'(state_o), 64'd3);
    rd_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_state", 64'(state_o), 64'd0);
    $display("after drain+clear: state=%0d", state_o);

    // Reset during CAPTURE with level=5.
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc = 8'(8'h04 + 4 * i); result = 32'hE000_0000 | 32'(i);
      tick();
    end
    check("midcap_level", 64'(level), 64'd5);
    check("midcap_state", 64'(state_o), 64'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_state", 64'(state_o), 64'd0);
    check("midrst_level", 64'(level), 64'd0);
    check("midrst_valid", 64'(rd_valid), 64'd0);
    check("midrst_data", 64'(rd_data), 64'd0);
    $display("mid-capture reset: state=%0d level=%0d valid=%0d", state_o, level, rd_valid);

    // pc held at 0x10 for three cycles, then 0x14.
    trig_pc = 8'h10;
    arm = 1'b1; tick(); arm = 1'b0;
    pc = 8'h10; result = 32'h5000_0000; tick();
    result = 32'h5000_0001; tick();
    result = 32'h5000_0002; tick();
    pc = 8'h14; result = 32'h5000_0003; tick();
`ifdef TRACE_PC_CHANGE_FILTER_EN
    check("filter_level", 64'(level), 64'd2);
`else
    check("filter_level", 64'(level), 64'd4);
`endif
    check("filter_head", 64'(rd_data), 64'h10_5000_0000);
    rd_ready = 1'b1; result = 32'h5000_0004; tick(); rd_ready = 1'b0;
`ifdef TRACE_PC_CHANGE_FILTER_EN
    check("filter_second", 64'(rd_data), 64'h14_5000_0003);
    check("filter_level2", 64'(level), 64'd1);
`else
    check("filter_second", 64'(rd_data), 64'h10_5000_0001);
    check("filter_level2", 64'(level), 64'd4);
`endif
    $display("filter: level=%0d rd_data=%010h", level, rd_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
